plp_bus_arbiter: RTL and testbench

- Parametrised multi-master, multi-slave bus interconnect for the PLP SoC.
- Round-robin arbitration over NUM_MASTERS requesters, e.g. CPU data port, CPU instruction port and a DMA/debug master.
- Each address is decoded to one of NUM_SLAVES memory-mapped modules (ROM, RAM, UART, switches, LEDs, PLPID, timer, sseg, ...).
- Adds slave wait states via an ack handshake, a bus timeout, and error responses for unmapped addresses.

---
 rtl/plp_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_plp_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plp_bus_arbiter.sv
// plp_bus_arbiter: round-robin multi-master to multi-slave bus interconnect.
// The upper address bits pick a slave. Slaves may insert wait states by
// holding off their ack. A transfer that gets no ack before the timeout,
// or that targets an unmapped region, completes with an error response.
module plp_bus_arbiter #(
  parameter  int unsigned NUM_MASTERS = 2,
  parameter  int unsigned NUM_SLAVES  = 11,
  parameter  int unsigned SEL_LSB     = 24,
  parameter  int unsigned TIMEOUT     = 255,
  localparam int unsigned GW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_rw,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [NUM_MASTERS-1:0]    m_err,
  output logic [31:0]               m_rdata,
  output logic [NUM_SLAVES-1:0]     s_sel,
  output logic                      s_rw,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  input  logic [NUM_SLAVES*32-1:0]  s_rdata,
  input  logic [NUM_SLAVES-1:0]     s_ack,
  output logic                      busy,
  output logic [GW-1:0]             grant_id
);

  localparam int unsigned IW = 32 - SEL_LSB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;

  logic [GW-1:0]           r_rr;
  logic [GW-1:0]           r_grant;
  logic [NUM_SLAVES-1:0]   r_sel;
  logic                    r_rw;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic [31:0]             r_cap;
  logic                    r_eflag;
  logic [31:0]             r_cnt;
  logic [NUM_MASTERS-1:0]  r_m_ack;
  logic [NUM_MASTERS-1:0]  r_m_err;
  logic [31:0]             r_m_rdata;
  logic                    r_busy;

  logic                    w_found;
  logic [GW-1:0]           w_gnt;
  logic                    w_g_rw;
  logic [31:0]             w_g_addr;
  logic [31:0]             w_g_wdata;
  logic [IW-1:0]           w_idx;
  logic                    w_mapped;
  logic [31:0]             w_eff;
  logic [NUM_SLAVES-1:0]   w_sel_new;
  logic                    w_ack;
  logic                    w_tmo;
  logic [31:0]             w_srdata;
  logic [NUM_MASTERS-1:0]  w_gnt_1h;

  // First requester at or after the pointer, searching upward with wrap.
  function automatic logic [GW:0] f_arb(input logic [NUM_MASTERS-1:0] req,
                                        input logic [GW-1:0]          rr);
    logic          found;
    logic [GW-1:0] g;
    logic [GW-1:0] cand;
    found = 1'b0;
    g     = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = GW'((32'(rr) + k) % NUM_MASTERS);
      if (!found && req[cand]) begin
        found = 1'b1;
        g     = cand;
      end
    end
    return {found, g};
  endfunction

  // Arbitration, request mux, address decode and slave response mux.
  always_comb begin
    {w_found, w_gnt} = f_arb(m_req, r_rr);
    w_g_rw    = 1'b0;
    w_g_addr  = '0;
    w_g_wdata = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (GW'(m) == w_gnt) begin
        w_g_rw    = m_rw[m];
        w_g_addr  = m_addr[m*32 +: 32];
        w_g_wdata = m_wdata[m*32 +: 32];
      end
    end
    w_idx    = w_g_addr[31:SEL_LSB];
    w_mapped = (32'(w_idx) < NUM_SLAVES);
    w_eff    = w_g_addr;
    w_eff[31:SEL_LSB] = '0;
    w_sel_new = '0;
    w_srdata  = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      w_sel_new[s] = w_mapped && (32'(w_idx) == s);
      if (r_sel[s]) w_srdata = w_srdata | s_rdata[s*32 +: 32];
    end
    // r_sel is one-hot, so masking picks only the selected slave's ack.
    w_ack = |(s_ack & r_sel);
    w_tmo = (TIMEOUT != 0) && ((r_cnt + 32'd1) == TIMEOUT);
    w_gnt_1h = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      w_gnt_1h[m] = (GW'(m) == r_grant);
    end
  end

  // Next-state logic for the IDLE -> XFER/RESP -> IDLE sequence.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_state_nx = w_mapped ? ST_XFER : ST_RESP;
      ST_XFER: if (w_ack || w_tmo) w_state_nx = ST_RESP;
      ST_RESP: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nx;
  end

  // Datapath: grant latch, slave strobe, timeout count and the response pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr      <= '0;
      r_grant   <= '0;
      r_sel     <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cap     <= '0;
      r_eflag   <= 1'b0;
      r_cnt     <= '0;
      r_m_ack   <= '0;
      r_m_err   <= '0;
      r_m_rdata <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (w_state_nx != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_m_ack   <= '0;
          r_m_err   <= '0;
          r_m_rdata <= '0;
          r_eflag   <= 1'b0;
          if (w_found) begin
            r_grant <= w_gnt;
            r_rw    <= w_g_rw;
            r_addr  <= w_eff;
            r_wdata <= w_g_wdata;
            r_sel   <= w_sel_new;
            r_cnt   <= '0;
            r_eflag <= !w_mapped;
          end
        end
        ST_XFER: begin
          r_cnt <= r_cnt + 32'd1;
          // An ack in the same cycle as the timeout takes priority.
          if (w_ack) begin
            r_cap <= w_srdata;
            r_sel <= '0;
          end else if (w_tmo) begin
            r_sel   <= '0;
            r_eflag <= 1'b1;
          end
        end
        ST_RESP: begin
          r_m_ack   <= w_gnt_1h;
          r_m_err   <= r_eflag ? w_gnt_1h : '0;
          r_m_rdata <= (r_eflag || r_rw) ? '0 : r_cap;
          r_rr      <= ((32'(r_grant) + 32'd1) == NUM_MASTERS) ? '0 : r_grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m_ack    = r_m_ack;
  assign m_err    = r_m_err;
  assign m_rdata  = r_m_rdata;
  assign s_sel    = r_sel;
  assign s_rw     = r_rw;
  assign s_addr   = r_addr;
  assign s_wdata  = r_wdata;
  assign busy     = r_busy;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_plp_bus_arbiter.sv
// Bench for plp_bus_arbiter: directed and randomized transactions checked
// against a transaction-level model (round-robin pick, decode, latency).
module tb_plp_bus_arbiter;

  localparam int NM = 2;
  localparam int NS = 11;
  localparam int T  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req, m_rw, m_ack, m_err;
  logic [NM*32-1:0]  m_addr, m_wdata;
  logic [31:0]       m_rdata;
  logic [NS-1:0]     s_sel, s_ack;
  logic              s_rw;
  logic [31:0]       s_addr, s_wdata;
  logic [NS*32-1:0]  s_rdata;
  logic              busy;
  logic [0:0]        grant_id;

  int checks = 0;
  int errors = 0;

  bit          mreq   [NM];
  bit          mrw    [NM];
  logic [31:0] maddr  [NM];
  logic [31:0] mwdata [NM];
  logic [31:0] srd    [NS];
  int          rr;
  int          last_g;
  int          prev_g;

  always #5 clk = ~clk;

  plp_bus_arbiter #(
    .NUM_MASTERS(NM),
    .NUM_SLAVES (NS),
    .SEL_LSB    (24),
    .TIMEOUT    (T)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_rw    (m_rw),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .s_sel   (s_sel),
    .s_rw    (s_rw),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_ack   (s_ack),
    .busy    (busy),
    .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int m = 0; m < NM; m++) begin
      m_req[m]            = mreq[m];
      m_rw[m]             = mrw[m];
      m_addr[m*32 +: 32]  = maddr[m];
      m_wdata[m*32 +: 32] = mwdata[m];
    end
    for (int s = 0; s < NS; s++) s_rdata[s*32 +: 32] = srd[s];
  endtask

  task automatic newreq(input int m);
    int idx;
    idx       = $urandom_range(0, 12);
    maddr[m]  = (32'(idx) << 24) | ($urandom & 32'h00FF_FFFC);
    mrw[m]    = 1'($urandom_range(0, 1));
    mwdata[m] = $urandom;
    mreq[m]   = 1'b1;
  endtask

  // One transaction, entered at a negedge with the DUT idle. j is the XFER
  // cycle (0-based) in which the selected slave acks; j<0 means never.
  task automatic txn(input int j, input string tag, input bit fix, input logic [31:0] fixv);
    int          g, idx, lat, k, xlast;
    bit          mapped, err;
    logic [31:0] rd, eff;
    logic [NS-1:0] sel1h, noise;
    g = -1;
    for (int i = 0; i < NM; i++)
      if (g < 0 && mreq[(rr + i) % NM]) g = (rr + i) % NM;
    idx    = int'(maddr[g] >> 24);
    mapped = (idx < NS);
    eff    = maddr[g] & 32'h00FF_FFFF;
    sel1h  = '0;
    if (mapped) sel1h[idx] = 1'b1;
    for (int s = 0; s < NS; s++) srd[s] = $urandom;
    if (fix && mapped) srd[idx] = fixv;
    drive_inputs();
    if (!mapped) begin
      lat = 1; err = 1'b1; rd = '0; xlast = -1;
    end else if (j >= 0 && j < T) begin
      lat = j + 2; err = 1'b0; rd = mrw[g] ? 32'h0 : srd[idx]; xlast = j;
    end else begin
      lat = T + 1; err = 1'b1; rd = '0; xlast = T - 1;
    end
    @(posedge clk);
    for (k = 0; k <= T + 4; k++) begin
      @(negedge clk);
      if (m_ack !== '0) break;
      chk($sformatf("%s.busy@%0d", tag, k), 32'(busy), 32'd1);
      if (k <= xlast) begin
        chk($sformatf("%s.s_sel@%0d", tag, k), 32'(s_sel), 32'(sel1h));
        chk($sformatf("%s.s_addr@%0d", tag, k), s_addr, eff);
        chk($sformatf("%s.s_rw@%0d", tag, k), 32'(s_rw), 32'(mrw[g]));
        chk($sformatf("%s.s_wdata@%0d", tag, k), s_wdata, mwdata[g]);
      end else begin
        chk($sformatf("%s.s_sel_off@%0d", tag, k), 32'(s_sel), 32'd0);
      end
      noise = NS'($urandom);
      if (mapped) noise[idx] = (k == j);
      s_ack = noise;
    end
    s_ack = '0;
    chk({tag, ".latency"}, 32'(k), 32'(lat));
    chk({tag, ".m_ack"}, 32'(m_ack), 32'(1) << g);
    chk({tag, ".m_err"}, 32'(m_err), err ? (32'(1) << g) : 32'd0);
    chk({tag, ".m_rdata"}, m_rdata, rd);
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(g));
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    mreq[g] = 1'b0;
    drive_inputs();
    rr     = (g + 1) % NM;
    last_g = g;
  endtask

  initial begin
    rst     = 1'b0;
    m_req   = '0;
    m_rw    = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_ack   = '0;
    s_rdata = '0;
    rr      = 0;
    last_g  = 0;
    for (int m = 0; m < NM; m++) begin
      mreq[m] = 1'b0; mrw[m] = 1'b0; maddr[m] = '0; mwdata[m] = '0;
    end
    for (int s = 0; s < NS; s++) srd[s] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst.m_ack", 32'(m_ack), 32'd0);
    chk("rst.m_err", 32'(m_err), 32'd0);
    chk("rst.m_rdata", m_rdata, 32'd0);
    chk("rst.s_sel", 32'(s_sel), 32'd0);
    chk("rst.s_rw", 32'(s_rw), 32'd0);
    chk("rst.s_addr", s_addr, 32'd0);
    chk("rst.s_wdata", s_wdata, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.grant_id", 32'(grant_id), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single zero-wait read from slave 1.
    mreq[0] = 1'b1; mrw[0] = 1'b0; maddr[0] = 32'h0100_0010; mwdata[0] = '0;
    txn(0, "rd1", 1'b1, 32'hCAFE_F00D);

    // Both masters requesting continuously: grants must alternate.
    newreq(0); newreq(1);
    maddr[0] = 32'h0300_0040; maddr[1] = 32'h0500_0080;
    prev_g = -1;
    for (int i = 0; i < 8; i++) begin
      txn($urandom_range(0, 3), $sformatf("rr%0d", i), 1'b0, '0);
      if (i > 0) chk($sformatf("rr%0d.alternate", i), 32'(last_g), 32'(1 - prev_g));
      prev_g = last_g;
      newreq(last_g);
      maddr[last_g] = (32'($urandom_range(0, 10)) << 24) | 32'h100;
    end
    mreq[0] = 1'b0; mreq[1] = 1'b0;
    drive_inputs();
    @(negedge clk);

    // Write with three wait states to slave 4.
    mreq[1] = 1'b1; mrw[1] = 1'b1; maddr[1] = 32'h0400_0000; mwdata[1] = 32'h0000_00A5;
    txn(3, "wr", 1'b0, '0);

    // Unmapped region.
    mreq[0] = 1'b1; mrw[0] = 1'b0; maddr[0] = 32'h0B00_0000;
    txn(0, "unmap", 1'b0, '0);

    // Timeout on slave 2.
    mreq[0] = 1'b1; mrw[0] = 1'b0; maddr[0] = 32'h0200_0000;
    txn(-1, "tmo", 1'b0, '0);

    // Ack in the last cycle before timeout wins.
    mreq[1] = 1'b1; mrw[1] = 1'b0; maddr[1] = 32'h0200_0004;
    txn(T - 1, "simul", 1'b1, 32'h1234_5678);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      int jj;
      for (int m = 0; m < NM; m++)
        if (!mreq[m] && $urandom_range(0, 1) == 1) newreq(m);
      if (!mreq[0] && !mreq[1]) newreq($urandom_range(0, NM - 1));
      jj = $urandom_range(0, 9);
      if (jj == 9) jj = -1;
      txn(jj, $sformatf("rnd%0d", i), 1'b0, '0);
    end
    mreq[0] = 1'b0; mreq[1] = 1'b0;
    drive_inputs();
    @(negedge clk);

    // Reset while slave 1 is stalling an M1 read.
    mreq[1] = 1'b1; mrw[1] = 1'b0; maddr[1] = 32'h0100_0000;
    drive_inputs();
    s_ack = '0;
    @(posedge clk);
    @(negedge clk);
    chk("mid.s_sel", 32'(s_sel), 32'h002);
    chk("mid.grant_id", 32'(grant_id), 32'd1);
    chk("mid.busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst.s_sel", 32'(s_sel), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.m_ack", 32'(m_ack), 32'd0);
    chk("arst.grant_id", 32'(grant_id), 32'd0);
    chk("arst.s_addr", s_addr, 32'd0);
    mreq[0] = 1'b0; mreq[1] = 1'b0;
    drive_inputs();
    @(negedge clk);
    rst = 1'b1;
    rr  = 0;
    @(negedge clk);
    mreq[1] = 1'b1; mrw[1] = 1'b0; maddr[1] = 32'h0100_0020;
    txn(1, "postrst", 1'b0, '0);
    newreq(0); newreq(1);
    txn(0, "postrst2", 1'b0, '0);
    mreq[0] = 1'b0; mreq[1] = 1'b0;
    drive_inputs();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
